// File: rtl/seg_scan_if.sv
// Display-pin bundle (anodes + segments) and decoded-result signals for seg_scan_reader.
// The master side drives the pins and receives results; the slave side is the reader.
interface seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [6:0]              seg_in;
    logic [NUM_DIGITS-1:0]   an_in;
    logic [4*NUM_DIGITS-1:0] digits_out;
    logic [NUM_DIGITS-1:0]   valid_out;
    logic                    frame_done;
    logic                    err;
    logic [IW-1:0]           err_digit;

    modport master (
        output seg_in, an_in,
        input  digits_out, valid_out, frame_done, err, err_digit
    );

    modport slave (
        input  seg_in, an_in,
        output digits_out, valid_out, frame_done, err, err_digit
    );
endinterface

// File: rtl/seg_scan_reader.sv
// Recovers BCD digits from a multiplexed 7-segment bus: waits for a stable one-hot scan
// sample, decodes the segment pattern, tracks frame completion and flags illegal patterns.
module seg_scan_reader #(
    parameter int NUM_DIGITS = 4,
    parameter int SETTLE     = 3
) (
    input  logic      clk,
    input  logic      rst_n,
    seg_scan_if.slave bus
);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int SW = NUM_DIGITS + 7;
    localparam logic [4:0] SETTLE_L = 5'(SETTLE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } state_t;

    state_t          state_reg, state_next;
    logic [3:0]      cnt_reg, cnt_next;
    logic [4:0]      cnt_inc;
    logic [SW-1:0]   samp;
    logic [SW-1:0]   prev_reg;
    logic            same;
    logic            one_hot;
    logic            capture;

    logic [3:0]            dec_val;
    logic                  dec_legal;
    logic [IW-1:0]         idx;
    logic [NUM_DIGITS-1:0] mask_reg;
    logic [NUM_DIGITS-1:0] mask_set;
    logic                  frame_done_reg;
    logic                  err_reg;
    logic [IW-1:0]         err_digit_reg;

    // The newest sample is compared against the one registered on the previous edge, so
    // pins stable across edges 0..SETTLE produce a capture exactly on edge SETTLE.
    assign samp    = {bus.an_in, bus.seg_in};
    assign same    = (samp == prev_reg);
    assign one_hot = $onehot(bus.an_in);
    assign cnt_inc = {1'b0, cnt_reg} + 5'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            prev_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            prev_reg  <= samp;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        capture    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                cnt_next = 4'd0;
                if (one_hot) begin
                    state_next = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!one_hot) begin
                    state_next = ST_IDLE;
                    cnt_next   = 4'd0;
                end else if (!same) begin
                    cnt_next = 4'd0;
                end else if (cnt_inc == SETTLE_L) begin
                    capture    = 1'b1;
                    state_next = ST_HOLD;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_inc[3:0];
                end
            end
            ST_HOLD: begin
                if (!same) begin
                    cnt_next   = 4'd0;
                    state_next = one_hot ? ST_SETTLE : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Segment pattern to BCD; all-dark is a legal blank shown as 4'hF.
    always_comb begin
        dec_val   = 4'hF;
        dec_legal = 1'b1;
        case (bus.seg_in)
            7'b1111110: dec_val = 4'd0;
            7'b0110000: dec_val = 4'd1;
            7'b1101101: dec_val = 4'd2;
            7'b1111001: dec_val = 4'd3;
            7'b0110011: dec_val = 4'd4;
            7'b1011011: dec_val = 4'd5;
            7'b1011111: dec_val = 4'd6;
            7'b1110000: dec_val = 4'd7;
            7'b1111111: dec_val = 4'd8;
            7'b1111011: dec_val = 4'd9;
            7'b0000000: dec_val = 4'hF;
            default:    dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bus.an_in[i]) begin
                idx = IW'(i);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic [3:0] digit_reg;
            logic       valid_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    digit_reg <= 4'hF;
                    valid_reg <= 1'b0;
                end else if (capture && dec_legal && bus.an_in[gi]) begin
                    digit_reg <= dec_val;
                    valid_reg <= 1'b1;
                end
            end

            assign bus.digits_out[4*gi +: 4] = digit_reg;
            assign bus.valid_out[gi]         = valid_reg;
        end
    endgenerate

    // Capture only fires on a one-hot sample, so OR-ing the anodes sets exactly one bit.
    assign mask_set = mask_reg | bus.an_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_reg       <= '0;
            frame_done_reg <= 1'b0;
            err_reg        <= 1'b0;
            err_digit_reg  <= '0;
        end else begin
            frame_done_reg <= 1'b0;
            err_reg        <= 1'b0;
            if (capture) begin
                if (dec_legal) begin
                    if (&mask_set) begin
                        frame_done_reg <= 1'b1;
                        mask_reg       <= '0;
                    end else begin
                        mask_reg <= mask_set;
                    end
                end else begin
                    err_reg       <= 1'b1;
                    err_digit_reg <= idx;
                end
            end
        end
    end

    assign bus.frame_done = frame_done_reg;
    assign bus.err        = err_reg;
    assign bus.err_digit  = err_digit_reg;
endmodule

// File: tb/tb_seg_scan_reader.sv
// Scoreboarded bench for seg_scan_reader: a run-length reference model predicts the outputs
// after every edge; a separate monitor compares them against the DUT on the falling edge.
module tb_seg_scan_reader;
    localparam int N  = 4;
    localparam int ST = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg_scan_if #(.NUM_DIGITS(N)) bus ();

    seg_scan_reader #(.NUM_DIGITS(N), .SETTLE(ST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [4*N-1:0] digits;
        logic [N-1:0]   valid;
        logic           fd;
        logic           er;
        logic [1:0]     ed;
    } snap_t;

    snap_t exp_q[$];
    int total = 0;
    int bad   = 0;
    int fd_seen = 0;

    logic [6:0] seg_tab [10];

    // Reference model state: outputs plus the length of the current run of identical samples.
    logic [3:0]   m_digit [N];
    logic [N-1:0] m_valid;
    logic [N-1:0] m_mask;
    logic [1:0]   m_ed;
    logic [N+6:0] m_last;
    int           m_run;

    function automatic logic lookup(input logic [6:0] s, output logic [3:0] v);
        v = 4'hF;
        if (s == 7'b0000000) return 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (seg_tab[k] == s) begin
                v = 4'(k);
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic model_edge();
        snap_t s;
        logic [3:0] v;
        logic fd = 1'b0;
        logic er = 1'b0;
        int   pos = 0;
        if (!rst_n) begin
            for (int k = 0; k < N; k++) m_digit[k] = 4'hF;
            m_valid = '0;
            m_mask  = '0;
            m_ed    = '0;
            m_last  = '0;
            m_run   = 0;
        end else begin
            if ({bus.an_in, bus.seg_in} == m_last) m_run++;
            else m_run = 1;
            m_last = {bus.an_in, bus.seg_in};
            if ($onehot(bus.an_in) && m_run == ST + 1) begin
                for (int k = 0; k < N; k++) if (bus.an_in[k]) pos = k;
                if (lookup(bus.seg_in, v)) begin
                    m_digit[pos] = v;
                    m_valid[pos] = 1'b1;
                    m_mask[pos]  = 1'b1;
                    if (m_mask == '1) begin
                        fd     = 1'b1;
                        m_mask = '0;
                    end
                end else begin
                    er   = 1'b1;
                    m_ed = 2'(pos);
                end
            end
        end
        s.digits = {m_digit[3], m_digit[2], m_digit[1], m_digit[0]};
        s.valid  = m_valid;
        s.fd     = fd;
        s.er     = er;
        s.ed     = m_ed;
        exp_q.push_back(s);
    endtask

    task automatic step(input logic r, input logic [N-1:0] an, input logic [6:0] seg);
        @(negedge clk);
        rst_n      = r;
        bus.an_in  = an;
        bus.seg_in = seg;
        @(posedge clk);
        model_edge();
    endtask

    task automatic hold(input logic [N-1:0] an, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) step(1'b1, an, seg);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // Monitor: every falling edge the DUT presents its registered outputs for the last edge.
    initial begin
        snap_t e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.digits_out, bus.valid_out, bus.frame_done, bus.err, bus.err_digit};
                total++;
                if (a.fd === 1'b1) fd_seen++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t: got digits=%h valid=%b fd=%b err=%b ed=%0d want digits=%h valid=%b fd=%b err=%b ed=%0d",
                             $time, a.digits, a.valid, a.fd, a.er, a.ed,
                             e.digits, e.valid, e.fd, e.er, e.ed);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int fd_before;
        seg_tab[0] = 7'b1111110; seg_tab[1] = 7'b0110000; seg_tab[2] = 7'b1101101;
        seg_tab[3] = 7'b1111001; seg_tab[4] = 7'b0110011; seg_tab[5] = 7'b1011011;
        seg_tab[6] = 7'b1011111; seg_tab[7] = 7'b1110000; seg_tab[8] = 7'b1111111;
        seg_tab[9] = 7'b1111011;
        bus.an_in  = '0;
        bus.seg_in = '0;

        // Reset held for three edges.
        for (int k = 0; k < 3; k++) step(1'b0, 4'b0000, 7'b0);
        #1;
        chk("reset_digits", 32'(bus.digits_out), 32'hFFFF);
        chk("reset_valid",  32'(bus.valid_out),  32'h0);
        chk("reset_fd_err", {30'b0, bus.frame_done, bus.err}, 32'h0);
        hold(4'b0000, 7'b0, 2);

        // Single capture of a '2' on digit 0: lands on the fourth edge, not before.
        hold(4'b0001, seg_tab[2], 3);
        #1;
        chk("single_early", 32'(bus.digits_out), 32'hFFFF);
        hold(4'b0001, seg_tab[2], 1);
        #1;
        chk("single_digit", 32'(bus.digits_out), 32'hFFF2);
        chk("single_valid", 32'(bus.valid_out),  32'h1);
        hold(4'b0001, seg_tab[2], 4);

        // Two full scans showing 4321.
        fd_before = fd_seen;
        for (int sc = 0; sc < 2; sc++)
            for (int d = 0; d < N; d++)
                hold(4'(1 << d), seg_tab[d + 1], 8);
        #1;
        chk("scan_digits", 32'(bus.digits_out), 32'h4321);
        chk("scan_valid",  32'(bus.valid_out),  32'hF);
        @(negedge clk);
        #1;
        chk("scan_fd_count", 32'(fd_seen - fd_before), 32'd2);

        // Illegal pattern on digit 2.
        hold(4'b0100, 7'b1000000, 4);
        #1;
        chk("illegal_err",   {31'b0, bus.err},  32'h1);
        chk("illegal_idx",   32'(bus.err_digit), 32'h2);
        chk("illegal_digit", 32'(bus.digits_out), 32'h4321);
        hold(4'b0100, 7'b1000000, 1);
        #1;
        chk("illegal_pulse", {31'b0, bus.err}, 32'h0);

        // Multi-hot anodes then a short blip on digit 1.
        hold(4'b0011, seg_tab[8], 10);
        hold(4'b0010, seg_tab[5], 2);
        hold(4'b0011, seg_tab[8], 3);
        #1;
        chk("glitch_digits", 32'(bus.digits_out), 32'h4321);

        // Reset while a '7' is settling on digit 0.
        hold(4'b0001, seg_tab[7], 2);
        step(1'b0, 4'b0000, 7'b0);
        step(1'b0, 4'b0000, 7'b0);
        #1;
        chk("midrst_digits", 32'(bus.digits_out), 32'hFFFF);
        chk("midrst_valid",  32'(bus.valid_out),  32'h0);
        hold(4'b0000, 7'b0, 2);

        // Randomized scan traffic with occasional resets.
        for (int t = 0; t < 500; t++) begin
            logic [N-1:0] an;
            logic [6:0]   seg;
            int           r;
            r = int'($urandom_range(0, 99));
            if (r < 80) an = 4'(1 << $urandom_range(0, N - 1));
            else        an = 4'($urandom_range(0, 15));
            r = int'($urandom_range(0, 99));
            if (r < 75)      seg = seg_tab[$urandom_range(0, 9)];
            else if (r < 85) seg = 7'b0000000;
            else             seg = 7'($urandom_range(0, 127));
            if ($urandom_range(0, 59) == 0) begin
                for (int k = 0; k < int'($urandom_range(1, 2)); k++) step(1'b0, an, seg);
            end
            hold(an, seg, int'($urandom_range(1, 7)));
        end

        hold(4'b0000, 7'b0, 3);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
